// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM encoding, default sizing and the BCD digit
// adjust helper used by the optional binary-to-BCD converter.
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  localparam int GATE_CYCLES_DEF = 48_000_000;
  localparam int CNT_W_DEF       = 32;
  localparam int BCD_DIGITS      = 8;
  localparam int BCD_W           = 4 * BCD_DIGITS;

  // Shift-add-3 step: every digit of 5 or more gets 3 added before the shift.
  function automatic logic [BCD_W-1:0] bcd_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic clk_48MHZ,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back flops to resolve metastability on d_i.
  always_ff @(posedge clk_48MHZ or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over a gate window of
// GATE_CYCLES clocks and reports the saturated count once per window.
// Optional macro FREQ_METER_BCD_EN adds a sequential 8-digit BCD
// conversion of every new result (freq_bcd / bcd_valid).
//
// Handshake: start is a one-cycle request sampled only in IDLE; freq_valid
// is a one-cycle pulse in the cycle freq_out/overflow change, and those two
// hold until the next pulse. bcd_valid likewise pulses when freq_bcd changes.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_48MHZ,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [BCD_W-1:0] freq_bcd,
  output logic             bcd_valid
`endif
);

  localparam int             GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_out_q, freq_out_d;
  logic             overflow_q, overflow_d;
  logic             freq_valid_q, freq_valid_d;

  logic             sig_sync;
  logic             hist_q;
  logic             edge_det;
  logic             terminal;
  logic             sat_hit;
  logic [CNT_W-1:0] edge_cnt_inc;

  sync_2ff u_sync (
    .clk_48MHZ (clk_48MHZ),
    .rst_n     (rst_n),
    .d_i       (sig_in),
    .q_o       (sig_sync)
  );

  // History flop: remembers the previous synchronized level for edge detect.
  always_ff @(posedge clk_48MHZ or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b0;
    else        hist_q <= sig_sync;
  end

  assign edge_det     = sig_sync & ~hist_q;
  assign terminal     = (state_q == GATE) && (gate_cnt_q == GATE_LAST);
  assign sat_hit      = edge_det && (edge_cnt_q == CNT_MAX);
  assign edge_cnt_inc = (edge_det && !sat_hit) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

  // Next-state and datapath: window sequencing, edge counting, result capture.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    freq_out_d   = freq_out_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Edges seen while idle are simply not counted.
        if (start || continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      GATE: begin
        if (terminal) begin
          // The terminal-cycle edge is part of this window's result.
          freq_out_d   = edge_cnt_inc;
          overflow_d   = sat_q | sat_hit;
          freq_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          sat_d        = 1'b0;
          state_d      = continuous ? GATE : IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
          edge_cnt_d = edge_cnt_inc;
          sat_d      = sat_q | sat_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_48MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      sat_q        <= 1'b0;
      freq_out_q   <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      sat_q        <= sat_d;
      freq_out_q   <= freq_out_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign busy       = (state_q == GATE);
  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;

`ifdef FREQ_METER_BCD_EN
  localparam int CW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d, acc_adj;
  logic [BCD_W-1:0] freq_bcd_q, freq_bcd_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic             conv_q, conv_d;
  logic             clamp_q, clamp_d;
  logic             bcd_valid_q, bcd_valid_d;

  // Double-dabble converter: loads on freq_valid (restarting any conversion
  // in flight) and shifts one binary bit per cycle, MSB first.
  always_comb begin
    bin_d       = bin_q;
    acc_d       = acc_q;
    bcnt_d      = bcnt_q;
    conv_d      = conv_q;
    clamp_d     = clamp_q;
    freq_bcd_d  = freq_bcd_q;
    bcd_valid_d = 1'b0;
    acc_adj     = bcd_adj(acc_q);
    if (freq_valid_q) begin
      bin_d   = freq_out_q;
      acc_d   = '0;
      bcnt_d  = CW'(CNT_W);
      conv_d  = 1'b1;
      // Results past eight digits cannot be represented; show all nines.
      clamp_d = (64'(freq_out_q) > 64'd99_999_999);
    end else if (conv_q) begin
      acc_d  = (acc_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[CNT_W-1]};
      bin_d  = bin_q << 1;
      bcnt_d = bcnt_q - CW'(1);
      if (bcnt_q == CW'(1)) begin
        conv_d      = 1'b0;
        bcd_valid_d = 1'b1;
        freq_bcd_d  = clamp_q ? {BCD_DIGITS{4'h9}} : acc_d;
      end
    end
  end

  // Converter registers.
  always_ff @(posedge clk_48MHZ or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      acc_q       <= '0;
      bcnt_q      <= '0;
      conv_q      <= 1'b0;
      clamp_q     <= 1'b0;
      freq_bcd_q  <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      bcnt_q      <= bcnt_d;
      conv_q      <= conv_d;
      clamp_q     <= clamp_d;
      freq_bcd_q  <= freq_bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign freq_bcd  = freq_bcd_q;
  assign bcd_valid = bcd_valid_q;
`endif

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have these parameters:
- GATE_CYCLES, 48_000_000, gate-window length in clk_48MHZ cycles (one window = 1 s at 48 MHz).
- CNT_W, 32, width of the edge counter and of freq_out.

REQ-002 The block SHALL have these ports:
- clk_48MHZ  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sig_in  in  1  asynchronous signal under measurement.
- start  in  1  one-cycle request to begin a window.
- continuous  in  1  when high, windows repeat back-to-back.
- busy  out  1  high while a window is open.
- freq_out  out  CNT_W  rising-edge count of the last completed window (Hz when the window is 1 s).
- freq_valid  out  1  one-cycle pulse when freq_out updates.
- overflow  out  1  the last result saturated.

Function
REQ-003 sig_in SHALL pass through a 2-flop synchronizer, then one history flop; a rising edge is detected when the synchronized value is 1 and the history flop is 0.
REQ-004 Edge-detect latency SHALL be 3 clk_48MHZ cycles from a sig_in rising edge.
REQ-005 Measurement is specified only for sig_in high and low phases of at least 2 cycles each (maximum 12 MHz).
REQ-006 The FSM SHALL have states IDLE and GATE.
- IDLE: on start=1 or continuous=1, clear gate_cnt and edge_cnt and go to GATE.
- GATE: gate_cnt increments from 0 to GATE_CYCLES-1.
- Terminal cycle (gate_cnt == GATE_CYCLES-1): go to GATE if continuous=1, otherwise to IDLE.
REQ-007 In GATE, edge_cnt SHALL increment by 1 on each detected edge and SHALL saturate at 2^CNT_W-1.
REQ-008 On the terminal cycle, the block SHALL register the result, with freq_valid high for exactly the next cycle:
- freq_out = edge_cnt plus the terminal-cycle edge, saturated.
- overflow = 1 if saturation occurred.
REQ-009 A continuous restart SHALL open the next window with zero idle cycles, with edge_cnt starting from 0 (the terminal-cycle edge belongs to the old window).
REQ-010 start asserted while in GATE SHALL be ignored.
REQ-011 continuous deasserted mid-window SHALL let the current window complete, then the FSM returns to IDLE.
REQ-012 busy SHALL equal (state == GATE).
REQ-013 freq_out and overflow SHALL hold their values until the next freq_valid.
REQ-014 Edges detected while in IDLE SHALL be discarded.

Reset
REQ-015 rst_n=0 SHALL immediately force:
- state IDLE;
- all counters and synchronizer flops to 0;
- freq_out=0, freq_valid=0, overflow=0, busy=0.
REQ-016 Reset mid-window SHALL abort the window with no freq_valid pulse.
REQ-017 After rst_n rises, the block SHALL wait for start or continuous.

Configuration
REQ-018 With macro FREQ_METER_BCD_EN defined, the block SHALL add these ports and behaviour:
- freq_bcd (out, 32): 8 BCD digits.
- bcd_valid (out, 1): completion pulse.
- A sequential shift-add-3 conversion of freq_out starts on each freq_valid, runs CNT_W cycles, and pulses bcd_valid for one cycle after the last shift.
- Values above 99_999_999 SHALL yield 0x99999999.
- A new freq_valid during a conversion SHALL restart the conversion.
- freq_bcd SHALL reset to 0.
REQ-019 Without FREQ_METER_BCD_EN, freq_bcd, bcd_valid and all conversion logic SHALL be absent.

Structure
REQ-020 Package freq_meter_pkg SHALL hold the state encoding (IDLE, GATE), the GATE_CYCLES/CNT_W defaults and the BCD digit count (8).
REQ-021 The synchronizer SHALL be sub-module sync_2ff (1-bit data, clk_48MHZ, rst_n).

Verification (bench uses GATE_CYCLES=100 unless stated)
REQ-022 sig_in period 10 cycles, one start pulse -> freq_out=10, overflow=0, freq_valid pulses once, 101 cycles after start.
REQ-023 continuous=1 with period 10 -> freq_valid pulses spaced exactly 100 cycles apart, each freq_out=10; after continuous drops, exactly one more pulse, then busy=0.
REQ-024 sig_in held at 1 or at 0 through a window -> freq_out=0.
REQ-025 CNT_W=4, sig_in period 4 (25 edges) -> freq_out=15, overflow=1.
REQ-026 rst_n pulsed low at gate_cnt=50 -> all outputs 0 at once, no freq_valid, busy=0 until the next start.
REQ-027 FREQ_METER_BCD_EN defined, GATE_CYCLES=1000, period 10 (freq_out=100) -> freq_bcd=0x00000100, with bcd_valid CNT_W+1 cycles after freq_valid.
